xsim_msg_deframer: RTL

XSIM_MSG_DEFRAMER -- requirements
Module: xsim_msg_deframer

---
 rtl/xsim_msg_deframer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/xsim_msg_deframer.sv
// Message deframer: splits a beat stream into {chan,len} headers and payload words,
// queues payload in a first-word-fall-through FIFO. Define XSIM_DEFRAMER_ERRCNT_EN for err_count.
module xsim_msg_deframer #(
    parameter int DEPTH   = 16,
    parameter int MAX_LEN = 255
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        src_rdy,
    input  logic [31:0] beat,
    output logic        dst_rdy,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [15:0] out_chan,
    output logic        out_last,
    output logic        err_pulse
`ifdef XSIM_DEFRAMER_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);
    localparam logic [16:0]   MAX_LEN_EXT = 17'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_HDR,
        ST_PAYLOAD,
        ST_DROP
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [15:0] chan;
        logic        last;
    } entry_t;

    state_t        state_q, state_d;
    logic [15:0]   remaining_q, remaining_d;
    logic [15:0]   chan_q, chan_d;
    logic          err_q, err_d;
    logic          ready_en_q;

    logic          accept;
    logic          push, push_last;
    logic          pop;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [15:0]   hdr_chan;
    logic [15:0]   hdr_len;
    logic          len_zero;
    logic          len_too_big;

    assign hdr_chan    = beat[31:16];
    assign hdr_len     = beat[15:0];
    assign len_zero    = (hdr_len == 16'd0);
    assign len_too_big = ({1'b0, hdr_len} > MAX_LEN_EXT);

    // Back-pressure only while payload is being queued; headers and dropped
    // beats never need FIFO space. Uses the pre-edge count, so a pop in the
    // same cycle does not reopen the gate until the next cycle.
    assign dst_rdy = ready_en_q &&
                     ((state_q != ST_PAYLOAD) || (count_q < DEPTH_CNT));
    assign accept  = src_rdy && dst_rdy;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Parser next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        remaining_d = remaining_q;
        chan_d      = chan_q;
        err_d       = 1'b0;
        push        = 1'b0;
        push_last   = 1'b0;

        if (accept) begin
            unique case (state_q)
                ST_HDR: begin
                    if (len_zero) begin
                        err_d = 1'b1;
                    end else if (len_too_big) begin
                        err_d       = 1'b1;
                        remaining_d = hdr_len;
                        state_d     = ST_DROP;
                    end else begin
                        chan_d      = hdr_chan;
                        remaining_d = hdr_len;
                        state_d     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    push        = 1'b1;
                    push_last   = (remaining_q == 16'd1);
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
                ST_DROP: begin
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) begin
                        state_d = ST_HDR;
                    end
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parser state
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_HDR;
            remaining_q <= '0;
            chan_q      <= '0;
            err_q       <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            remaining_q <= remaining_d;
            chan_q      <= chan_d;
            err_q       <= err_d;
            ready_en_q  <= 1'b1;
        end
    end

    assign err_pulse = err_q;

    // ------------------------------------------------------------------
    // Payload FIFO
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; an empty FIFO gates the outputs
    // to zero instead, which gives the same reset-visible behaviour.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= '{data: beat, chan: chan_q, last: push_last};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Head entry is stable until popped, so outputs hold under back-pressure.
    assign head     = mem[rd_ptr_q];
    assign out_data = out_valid ? head.data : 32'd0;
    assign out_chan = out_valid ? head.chan : 16'd0;
    assign out_last = out_valid ? head.last : 1'b0;

`ifdef XSIM_DEFRAMER_ERRCNT_EN
    // Saturating count of rejected headers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            err_count <= '0;
        end else if (err_q && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule
